// File: rtl/light_velocity_tracker_pkg.sv
// Shared types for the light velocity tracker: FSM states, the
// sign-magnitude velocity record and the signed-to-sign/magnitude helper.
package tracker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Width of the generic signed value handled by abs_sign(); callers
    // sign-extend their displacement into it and narrow the magnitude back.
    localparam int MAG_W = 32;

    typedef struct packed {
        logic             neg;
        logic [MAG_W-1:0] mag;
    } velocity_t;

    // Splits a signed value into sign and magnitude; zero is never negative.
    function automatic velocity_t abs_sign(input logic signed [MAG_W-1:0] d);
        velocity_t v;
        v.neg = d[MAG_W-1];
        v.mag = v.neg ? -d : d;
        return v;
    endfunction

endpackage

// File: rtl/light_velocity_tracker_divider.sv
// Restoring unsigned divider, one quotient bit per clock. A start pulse
// loads the operands; done_out pulses once DIVIDEND_W cycles later and the
// quotient then holds until the next start. Dividing by zero yields all-ones.
module seq_divider #(
    parameter int DIVIDEND_W = 11,
    parameter int DIVISOR_W  = 16,
    parameter int QUOT_W     = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic [DIVIDEND_W-1:0] dividend_in,
    input  logic [DIVISOR_W-1:0]  divisor_in,
    output logic [QUOT_W-1:0]     quot_out,
    output logic                  done_out,
    output logic                  busy_out
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [CNT_W-1:0]      r_count;
    logic                  r_busy;
    logic                  r_done;

    logic [DIVISOR_W:0]    w_shift;
    logic [DIVISOR_W:0]    w_diff;
    logic                  w_ge;

    // Partial remainder with the next dividend bit shifted in, and the trial subtraction.
    assign w_shift = {r_rem, r_quot[DIVIDEND_W-1]};
    assign w_diff  = w_shift - {1'b0, r_divisor};
    assign w_ge    = (w_shift >= {1'b0, r_divisor});

    // Load on start, then retire one quotient bit per cycle until the count runs out.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (start_in) begin
            // NOTE: non-blocking assignments here so every register in this
            // block samples the pre-edge values, exactly like real flops.
            r_rem     <= '0;
            r_quot    <= dividend_in;
            r_divisor <= divisor_in;
            r_count   <= CNT_W'(DIVIDEND_W);
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
        end else if (r_busy) begin
            r_rem   <= w_ge ? w_diff[DIVISOR_W-1:0] : w_shift[DIVISOR_W-1:0];
            r_quot  <= {r_quot[DIVIDEND_W-2:0], w_ge};
            r_count <= r_count - 1'b1;
            if (r_count == CNT_W'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign quot_out = QUOT_W'(r_quot);
    assign done_out = r_done;
    assign busy_out = r_busy;

endmodule

// File: rtl/light_velocity_tracker.sv
// Light blob velocity tracker. In measured mode it follows one continuous
// lit streak, then divides the end-minus-start displacement by the number of
// sample intervals to get per-axis velocity. In manual mode a debounced
// button steps the velocity magnitudes for bring-up without a camera.
module light_velocity_tracker
    import tracker_pkg::*;
#(
    parameter int X_WIDTH     = 11,
    parameter int Y_WIDTH     = 10,
    parameter int V_WIDTH     = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int MIN_SAMPLES = 2,
    parameter int TIMEOUT     = 3000000,
    parameter int STEP_MAX    = 6
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               mode_in,
    input  logic               step_in,
    input  logic               step_x_in,
    input  logic               step_y_in,
    input  logic               neg_y_in,
    input  logic               valid_in,
    input  logic               light_in,
    input  logic [X_WIDTH-1:0] x_in,
    input  logic [Y_WIDTH-1:0] y_in,
    output logic [V_WIDTH-1:0] vx_out,
    output logic [V_WIDTH-1:0] vy_out,
    output logic               vx_neg_out,
    output logic               vy_neg_out,
    output logic               busy_out,
    output logic               valid_out
);

    // Both dividers share one width so they always finish on the same cycle.
    localparam int DIV_W = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    state_t                r_state, w_next;
    logic [X_WIDTH-1:0]    r_start_x, r_end_x;
    logic [Y_WIDTH-1:0]    r_start_y, r_end_y;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [TO_W-1:0]       r_to;
    logic                  r_dx_neg, r_dy_neg;
    logic                  r_done_x, r_done_y;
    logic                  r_step_prev;
    logic [V_WIDTH-1:0]    r_vx, r_vy;
    logic                  r_vx_neg, r_vy_neg;
    logic                  r_valid;

    logic                  w_hit, w_dark, w_streak_ok, w_timeout, w_start;
    logic signed [X_WIDTH:0] w_dx;
    logic signed [Y_WIDTH:0] w_dy;
    velocity_t             w_vel_x, w_vel_y;
    logic [CNT_WIDTH-1:0]  w_divisor;
    logic [V_WIDTH-1:0]    w_quot_x, w_quot_y;
    logic                  w_done_x, w_done_y, w_busy_x, w_busy_y;
    logic                  w_x_ready, w_y_ready;
    logic                  w_step_rise;
    logic [V_WIDTH-1:0]    w_vx_step, w_vy_step;

    assign w_hit       = valid_in & light_in;
    assign w_dark      = valid_in & ~light_in;
    assign w_streak_ok = (r_cnt >= CNT_WIDTH'(MIN_SAMPLES));
    assign w_timeout   = (r_to == TO_W'(TIMEOUT - 1));
    assign w_start     = ~mode_in & (r_state == TRACK) & w_dark & w_streak_ok;

    // Signed displacement with one guard bit, split into sign and magnitude.
    assign w_dx      = $signed({1'b0, r_end_x}) - $signed({1'b0, r_start_x});
    assign w_dy      = $signed({1'b0, r_end_y}) - $signed({1'b0, r_start_y});
    assign w_vel_x   = abs_sign({{(MAG_W-X_WIDTH-1){w_dx[X_WIDTH]}}, w_dx});
    assign w_vel_y   = abs_sign({{(MAG_W-Y_WIDTH-1){w_dy[Y_WIDTH]}}, w_dy});
    assign w_divisor = r_cnt - CNT_WIDTH'(1);

    seq_divider #(.DIVIDEND_W(DIV_W), .DIVISOR_W(CNT_WIDTH), .QUOT_W(V_WIDTH)) u_div_x (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .start_in    (w_start),
        .dividend_in (DIV_W'(w_vel_x.mag)),
        .divisor_in  (w_divisor),
        .quot_out    (w_quot_x),
        .done_out    (w_done_x),
        .busy_out    (w_busy_x)
    );

    seq_divider #(.DIVIDEND_W(DIV_W), .DIVISOR_W(CNT_WIDTH), .QUOT_W(V_WIDTH)) u_div_y (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .start_in    (w_start),
        .dividend_in (DIV_W'(w_vel_y.mag)),
        .divisor_in  (w_divisor),
        .quot_out    (w_quot_y),
        .done_out    (w_done_y),
        .busy_out    (w_busy_y)
    );

    // An axis is ready once its done pulse has been seen and the divider is idle.
    assign w_x_ready = (r_done_x | w_done_x) & ~w_busy_x;
    assign w_y_ready = (r_done_y | w_done_y) & ~w_busy_y;

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= IDLE;
        else           r_state <= w_next;
    end

    // Next-state logic; manual mode pins the FSM in IDLE, aborting any streak.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_next unassigned,
        // which would otherwise infer a latch.
        w_next = r_state;
        if (mode_in) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_hit) w_next = TRACK;
                TRACK:   if (w_dark)                    w_next = w_streak_ok ? DIVIDE : IDLE;
                         else if (!valid_in && w_timeout) w_next = IDLE;
                DIVIDE:  if (w_x_ready && w_y_ready) w_next = DONE;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Streak capture: first/last positions, saturating sample count, idle-gap timeout.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_start_x <= '0;
            r_start_y <= '0;
            r_end_x   <= '0;
            r_end_y   <= '0;
            r_cnt     <= '0;
            r_to      <= '0;
        end else if (!mode_in) begin
            if (r_state == IDLE && w_hit) begin
                r_start_x <= x_in;
                r_start_y <= y_in;
                r_end_x   <= x_in;
                r_end_y   <= y_in;
                r_cnt     <= CNT_WIDTH'(1);
                r_to      <= '0;
            end else if (r_state == TRACK) begin
                if (w_hit) begin
                    r_end_x <= x_in;
                    r_end_y <= y_in;
                    if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                    r_to    <= '0;
                end else if (!valid_in) begin
                    r_to <= r_to + 1'b1;
                end
            end
        end
    end

    // Displacement signs latched at divide start; per-axis done flags held until the next start.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_dx_neg <= 1'b0;
            r_dy_neg <= 1'b0;
            r_done_x <= 1'b0;
            r_done_y <= 1'b0;
        end else if (w_start) begin
            r_dx_neg <= w_vel_x.neg;
            r_dy_neg <= w_vel_y.neg;
            r_done_x <= 1'b0;
            r_done_y <= 1'b0;
        end else begin
            if (w_done_x) r_done_x <= 1'b1;
            if (w_done_y) r_done_y <= 1'b1;
        end
    end

    // Previous button level for rising-edge detection.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_step_prev <= 1'b0;
        else           r_step_prev <= step_in;
    end

    assign w_step_rise = step_in & ~r_step_prev;
    assign w_vx_step   = (r_vx >= V_WIDTH'(STEP_MAX)) ? '0 : r_vx + 1'b1;
    assign w_vy_step   = (r_vy >= V_WIDTH'(STEP_MAX)) ? '0 : r_vy + 1'b1;

    // Output registers: manual stepping, or publishing a finished measurement.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vx     <= '0;
            r_vy     <= '0;
            r_vx_neg <= 1'b0;
            r_vy_neg <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (mode_in) begin
                r_vx_neg <= 1'b0;
                r_vy_neg <= neg_y_in;
                if (w_step_rise && step_x_in) r_vx <= w_vx_step;
                if (w_step_rise && step_y_in) r_vy <= w_vy_step;
                if ((w_step_rise && (step_x_in || step_y_in)) || (neg_y_in != r_vy_neg))
                    r_valid <= 1'b1;
            end else if (r_state == DONE) begin
                r_vx     <= w_quot_x;
                r_vy     <= w_quot_y;
                // A magnitude that floors to zero is reported as positive zero.
                r_vx_neg <= r_dx_neg && (w_quot_x != '0);
                r_vy_neg <= r_dy_neg && (w_quot_y != '0);
                r_valid  <= 1'b1;
            end
        end
    end

    assign vx_out     = r_vx;
    assign vy_out     = r_vy;
    assign vx_neg_out = r_vx_neg;
    assign vy_neg_out = r_vy_neg;
    assign valid_out  = r_valid;
    assign busy_out   = (r_state == TRACK) || (r_state == DIVIDE);

endmodule

// File: tb/tb_light_velocity_tracker.sv
// Scoreboard bench for light_velocity_tracker: expected velocities are pushed
// when a streak ends or a manual step is driven, and popped on valid_out.
module tb_light_velocity_tracker;

    localparam int LAT = 13;    // max(X_WIDTH, Y_WIDTH) + 2

    logic        clk_in, rst_n_in, mode_in, step_in, step_x_in, step_y_in, neg_y_in;
    logic        valid_in, light_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic [15:0] vx_out, vy_out;
    logic        vx_neg_out, vy_neg_out, busy_out, valid_out;

    typedef struct {
        int vx;
        int vy;
        bit vxn;
        bit vyn;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    light_velocity_tracker #(.TIMEOUT(100)) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .mode_in    (mode_in),
        .step_in    (step_in),
        .step_x_in  (step_x_in),
        .step_y_in  (step_y_in),
        .neg_y_in   (neg_y_in),
        .valid_in   (valid_in),
        .light_in   (light_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .vx_out     (vx_out),
        .vy_out     (vy_out),
        .vx_neg_out (vx_neg_out),
        .vy_neg_out (vy_neg_out),
        .busy_out   (busy_out),
        .valid_out  (valid_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int vx, input int vy, input bit vxn, input bit vyn, input int c);
        exp_t e;
        e.vx = vx; e.vy = vy; e.vxn = vxn; e.vyn = vyn; e.cyc = c;
        return e;
    endfunction

    // Reference: floor(|end - start| / (samples - 1)) per axis, sign of the displacement.
    function automatic exp_t model(input int x0, input int y0, input int x1, input int y1,
                                   input int n, input int c);
        int dx = x1 - x0;
        int dy = y1 - y0;
        return mk((dx < 0 ? -dx : dx) / (n - 1), (dy < 0 ? -dy : dy) / (n - 1),
                  dx < 0, dy < 0, c);
    endfunction

    task automatic step_cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step_cycle();
    endtask

    task automatic lit(input int x, input int y);
        valid_in = 1'b1; light_in = 1'b1;
        x_in = 11'(x);   y_in = 10'(y);
        step_cycle();
        valid_in = 1'b0; light_in = 1'b0;
    endtask

    task automatic dark();
        valid_in = 1'b1; light_in = 1'b0;
        step_cycle();
        valid_in = 1'b0;
    endtask

    // Output monitor: every valid_out strobe must match the oldest expectation.
    always @(negedge clk_in) begin
        if (rst_n_in && valid_out) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", valid_out, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("vx",        vx_out,     e.vx);
                check("vy",        vy_out,     e.vy);
                check("vx_neg",    vx_neg_out, e.vxn);
                check("vy_neg",    vy_neg_out, e.vyn);
                check("valid_cyc", cyc,        e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int seq [8] = '{1, 2, 3, 4, 5, 6, 0, 1};
        mode_in = 0; step_in = 0; step_x_in = 0; step_y_in = 0; neg_y_in = 0;
        valid_in = 0; light_in = 0; x_in = '0; y_in = '0;
        rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_vx",    vx_out,     0);
        check("rst_vy",    vy_out,     0);
        check("rst_vxn",   vx_neg_out, 0);
        check("rst_vyn",   vy_neg_out, 0);
        check("rst_busy",  busy_out,   0);
        check("rst_valid", valid_out,  0);
        #2 rst_n_in = 1'b1;
        step_cycle();

        // Positive x, negative y streak.
        lit(100, 200);
        check("busy_track", busy_out, 1);
        lit(110, 190); lit(120, 180); lit(130, 170);
        dark();
        sb.push_back(model(100, 200, 130, 170, 4, cyc + LAT));
        check("busy_divide", busy_out, 1);
        idle(16);

        // Single-sample streak is discarded.
        lit(300, 300);
        dark();
        check("busy_short", busy_out, 0);
        check("vx_hold",    vx_out,   10);
        check("vy_hold",    vy_out,   10);
        idle(16);

        // Zero displacement: no negative zero.
        repeat (5) lit(50, 60);
        dark();
        sb.push_back(model(50, 60, 50, 60, 5, cyc + LAT));
        idle(16);

        // Timeout after 100 idle cycles, then a fresh streak with flooring.
        lit(1, 1); lit(2, 2); lit(3, 3);
        idle(99);
        check("busy_to_99", busy_out, 1);
        idle(1);
        check("busy_to_100", busy_out, 0);
        idle(3);
        lit(200, 0); lit(190, 5); lit(180, 9);
        dark();
        sb.push_back(model(200, 0, 180, 9, 3, cyc + LAT));
        idle(16);

        // Asynchronous reset in the middle of a divide.
        lit(10, 10); lit(20, 30);
        dark();
        idle(5);
        #2 rst_n_in = 1'b0;
        #1;
        check("rst_mid_vx",   vx_out,     0);
        check("rst_mid_vy",   vy_out,     0);
        check("rst_mid_vxn",  vx_neg_out, 0);
        check("rst_mid_busy", busy_out,   0);
        @(posedge clk_in);
        #3 rst_n_in = 1'b1;
        idle(20);

        // Switching to manual mode mid-divide aborts the measurement.
        lit(0, 0); lit(40, 40);
        dark();
        idle(4);
        mode_in = 1'b1;
        idle(2);
        check("busy_mode_abort", busy_out, 0);
        mode_in = 1'b0;
        idle(20);
        check("vx_after_abort", vx_out, 0);

        // Manual stepping of x with wrap at STEP_MAX.
        mode_in = 1'b1; step_x_in = 1'b1;
        idle(2);
        for (int i = 0; i < 8; i++) begin
            step_in = 1'b1;
            step_cycle();
            sb.push_back(mk(seq[i], 0, 0, 0, cyc));
            step_in = 1'b0;
            step_cycle();
        end
        // Holding the button gives one increment only.
        step_in = 1'b1;
        step_cycle();
        sb.push_back(mk(2, 0, 0, 0, cyc));
        idle(5);
        step_in = 1'b0;
        step_cycle();
        check("vx_held_step", vx_out, 2);
        // Both axes on the same edge.
        step_y_in = 1'b1; step_in = 1'b1;
        step_cycle();
        sb.push_back(mk(3, 1, 0, 0, cyc));
        step_in = 1'b0;
        step_cycle();
        // y sign follows neg_y_in with a valid strobe on each change.
        neg_y_in = 1'b1;
        step_cycle();
        sb.push_back(mk(3, 1, 0, 1, cyc));
        idle(2);
        neg_y_in = 1'b0;
        step_cycle();
        sb.push_back(mk(3, 1, 0, 0, cyc));
        idle(2);

        // Back to measured mode keeps the manual values.
        mode_in = 1'b0; step_x_in = 1'b0; step_y_in = 1'b0;
        idle(3);
        check("vx_keep", vx_out, 3);
        check("vy_keep", vy_out, 1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) step_cycle();
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/light_velocity_tracker.md
Name: light_velocity_tracker

Overview:
- Measures the velocity of a tracked light blob from the camera pixel stream.
- Records the first and last blob positions of one continuous lit streak and counts its samples, then divides signed displacement by elapsed samples to give per-axis velocity in pixels/sample.
- Supports a manual mode in which velocity is stepped by a button, for bring-up without the camera.
- Feeds the physics/simulation block with sign-magnitude vx/vy plus a one-cycle valid strobe.

Parameters:
- X_WIDTH, 11, width of x coordinate.
- Y_WIDTH, 10, width of y coordinate.
- V_WIDTH, 16, width of velocity magnitude outputs.
- CNT_WIDTH, 16, width of streak sample counter.
- MIN_SAMPLES, 2, minimum lit samples for a streak to count (must be >= 2).
- TIMEOUT, 3000000, clk_in cycles without valid_in in TRACK before abort.
- STEP_MAX, 6, manual-mode maximum magnitude before wrapping to 0.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- mode_in  in  1  0 = measured, 1 = manual
- step_in  in  1  manual step button level (already debounced)
- step_x_in  in  1  manual step targets x
- step_y_in  in  1  manual step targets y
- neg_y_in  in  1  manual-mode y sign
- valid_in  in  1  pixel sample qualifier
- light_in  in  1  blob detected in this sample
- x_in  in  X_WIDTH  blob x
- y_in  in  Y_WIDTH  blob y
- vx_out  out  V_WIDTH  |vx|
- vy_out  out  V_WIDTH  |vy|
- vx_neg_out  out  1  vx negative
- vy_neg_out  out  1  vy negative
- busy_out  out  1  high in TRACK or DIVIDE
- valid_out  out  1  one-cycle strobe on new velocity

Behaviour:
- Reset (rst_n_in low, asynchronous): all outputs 0, FSM in IDLE, counters 0, step edge register 0.
- Measured-mode FSM (mode_in = 0) has four states: IDLE, TRACK, DIVIDE, DONE.
  - IDLE: on valid_in & light_in, latch start = end = (x_in, y_in), cnt = 1, go to TRACK.
  - TRACK, valid_in & light_in: end <= sample; cnt increments and saturates at all-ones; timeout counter clears.
  - TRACK, valid_in & !light_in: if cnt >= MIN_SAMPLES go to DIVIDE, else discard and go to IDLE with no valid_out.
  - TRACK, no valid_in: timeout counter increments; on reaching TIMEOUT go to IDLE, discarding the streak.
  - DIVIDE entry: dx = end_x - start_x and dy = end_y - start_y, taken as signed with one extra bit. Latch the signs and magnitudes. Start both dividers with divisor cnt - 1.
  - DIVIDE: wait until both done flags are set. Dividers finish simultaneously, but each done is held in its own flag.
  - DONE: load vx_out/vy_out/neg flags, assert valid_out for exactly 1 cycle, return to IDLE.
- Latency from the terminating dark sample to valid_out is DIV_W + 2 cycles, where DIV_W = max(X_WIDTH, Y_WIDTH).
- Arithmetic: quotient is floor(|d| / (cnt - 1)), zero-extended to V_WIDTH. If |d| = 0, the magnitude is 0 and the neg flag is 0 (no negative zero).
- Outputs hold their last value between updates. busy_out = (state is TRACK or DIVIDE).
- Manual mode (mode_in = 1):
  - The FSM is forced to IDLE and dividers are ignored. A mode switch mid-streak or mid-divide aborts with no valid_out.
  - Rising edge of step_in (registered previous value) with step_x_in: vx_out <= (vx_out >= STEP_MAX) ? 0 : vx_out + 1. Same for y with step_y_in.
  - Both axes may step on the same edge.
  - vy_neg_out follows neg_y_in every cycle; vx_neg_out = 0.
  - valid_out pulses 1 cycle on each edge that changes an axis, and also when neg_y_in changes.
- Switching from manual to measured keeps the current outputs until the next measurement.

Decomposition:
- Package tracker_pkg holds:
  - the state enum (IDLE/TRACK/DIVIDE/DONE);
  - a velocity struct {mag, neg};
  - the function abs_sign().
- Sub-module seq_divider (parameters DIVIDEND_W, DIVISOR_W, QUOT_W):
  - restoring divider, one bit per cycle;
  - start_in pulse, done_out 1-cycle pulse DIVIDEND_W cycles later;
  - busy_out;
  - divide-by-zero returns all-ones, which is unreachable here.
- Two instances, one per axis.

Test Plan:
- Measured, positive-x / negative-y streak: 4 lit samples (100,200), (110,190), (120,180), (130,170), then a dark sample -> vx=10, vy=10, vx_neg=0, vy_neg=1, valid_out high exactly 1 cycle at DIV_W+2 = 13 cycles after the dark sample.
- Short streak: 1 lit sample then dark (MIN_SAMPLES=2) -> no valid_out, outputs unchanged, busy_out low the next cycle.
- Zero displacement: 5 lit samples all at (50,60) -> vx=vy=0, both neg=0, valid_out pulse.
- Timeout: TIMEOUT=100, 3 lit samples then valid_in low for 100 cycles -> back to IDLE with no valid_out; a subsequent streak measures correctly.
- Manual: mode=1, step_x held high, 8 step_in rising edges -> vx sequence 1,2,3,4,5,6,0,1. Holding step_in high gives only one increment. Toggling neg_y_in gives vy_neg_out toggling with a valid pulse.
- Reset mid-DIVIDE: rst_n_in low for 1 cycle asynchronously -> all outputs 0 immediately and no stale valid_out afterwards. A mode switch to 1 during DIVIDE aborts likewise, with no valid_out.
